// File: rtl/dff_debounce.sv
// Debounces the single-bit level from the upstream dff: a new level is accepted after CNT_MAX
// identical consecutive samples. Optional two-flop input synchronizer under DFF_DEBOUNCE_SYNC_EN.
module dff_debounce #(
  parameter int unsigned CNT_MAX = 4,
  parameter int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (CNT_MAX < 2 || CNT_MAX > 255) begin : g_bad_cnt_max
    $error("dff_debounce: CNT_MAX must be in 2..255");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {StIdleLo, StWaitHi, StIdleHi, StWaitLo} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             din_s;

`ifdef DFF_DEBOUNCE_SYNC_EN
  logic sync_q1, sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

  assign din_s = sync_q2;
`else
  // Upstream dff is already in the clk domain.
  assign din_s = din;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdleLo;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (state)
        StIdleLo: begin
          if (din_s) begin
            state <= StWaitHi;
            cnt   <= CntOne;
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        StWaitHi: begin
          if (!din_s) begin
            state <= StIdleLo;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CntLast) begin
            state <= StIdleHi;
            cnt   <= '0;
            dout  <= 1'b1;
            rise  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
        StIdleHi: begin
          if (!din_s) begin
            state <= StWaitLo;
            cnt   <= CntOne;
            busy  <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        StWaitLo: begin
          if (din_s) begin
            state <= StIdleHi;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CntLast) begin
            state <= StIdleLo;
            cnt   <= '0;
            dout  <= 1'b0;
            fall  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CntOne;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/dff_debounce.md
Name: dff_debounce

Overview:
- Input conditioning stage that sits directly downstream of the single-bit `dff` register.
- Consumes its `dout` as `din` and produces a glitch-free level, plus one-cycle rise and fall strobes for control logic.
- A new level is accepted only after it has been sampled for `CNT_MAX` consecutive clocks. Shorter pulses are rejected.

Parameters:
- CNT_MAX, default 4: consecutive identical samples needed to accept a new level. Legal range 2..255; elaboration error outside that range.
- CNT_W, default $clog2(CNT_MAX+1): width of the stability counter. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  synchronous, active-high reset
- din  input  1  raw level from the upstream dff stage
- dout  output  1  debounced level
- rise  output  1  one-cycle strobe when dout changes 0->1
- fall  output  1  one-cycle strobe when dout changes 1->0
- busy  output  1  high while a candidate level change is being qualified

Behaviour:
- Clocking and reset:
  - One clock, `clk`. Reset `rst` is synchronous and active-high.
  - Every flop updates only on the rising edge of `clk`.
- Reset (rst=1 sampled at an edge):
  - state=IDLE_LO, cnt=0.
  - dout=0, rise=0, fall=0, busy=0.
  - rst takes priority over all other activity.
  - A reset in the middle of qualification abandons the pending change and emits no strobe.
- States: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO. Encoding is free.
- IDLE_LO:
  - din=1 -> WAIT_HI, cnt<=1.
  - Otherwise stay, cnt<=0.
- WAIT_HI:
  - din=0 -> IDLE_LO, cnt<=0. Glitch rejected, no strobe.
  - din=1 and cnt==CNT_MAX-1 -> IDLE_HI, dout<=1, rise<=1, cnt<=0.
  - din=1 otherwise -> cnt<=cnt+1.
- IDLE_HI and WAIT_LO: mirror images of the above, with din inverted, dout<=0 and fall<=1.
- Registered outputs:
  - rise and fall are registered, high for exactly one cycle, and never both high.
  - busy is registered and equals 1 exactly while the state is WAIT_HI or WAIT_LO.
- Latency:
  - If din first shows the new value at edge k and holds it, dout, rise or fall update at edge k+CNT_MAX-1.
  - Those outputs are visible after that edge.
- Counter:
  - cnt never exceeds CNT_MAX-1 and never wraps.
  - It is unsigned, CNT_W bits wide.
- Boundary conditions:
  - A pulse of CNT_MAX-1 samples returns to idle with no output change.
  - A pulse of CNT_MAX samples is accepted.
  - A din toggle on the same edge as qualification completion cannot occur, because qualification uses the sampled din itself.
  - Back-to-back changes are allowed: the cycle after a rise, a din=0 sample enters WAIT_LO immediately.
- No X propagation: dout, rise, fall and busy are always driven.

Optional Feature:
- Macro: DFF_DEBOUNCE_SYNC_EN.
- When defined:
  - din passes through a two-flop synchronizer before the state machine.
  - Both synchronizer flops reset synchronously to 0.
  - All latencies grow by 2 cycles, so the first new sample reaches the FSM at edge k+2.
- When undefined:
  - din feeds the state machine directly.
  - The upstream dff is already synchronous to clk, so the synchronizer is not needed.
- The port list is identical in both builds.

Test Plan (CNT_MAX=4, 20 ns clock, macro undefined unless stated):
1. Reset and idle:
   - Stimulus: rst=1 for 2 edges with din=1, then rst=0 with din held 1.
   - Required: dout=0, busy=0 and rise=0 during reset.
   - After release: busy=1 at the first edge; rise=1 for exactly one cycle and dout=1 at the 4th edge after release.
2. Glitch rejection:
   - Stimulus: from a settled dout=0, drive din=1 for 3 clocks, then 0.
   - Required: busy=1 for 3 cycles then 0; dout stays 0; rise never asserts.
3. Clean toggle:
   - Stimulus: din 0->1, hold 10 clocks, then 1->0, hold 10 clocks.
   - Required: rise at edge k+3 and fall at edge j+3, each exactly one cycle wide; final dout=0.
4. Mid-qualification reset:
   - Stimulus: din=1 for 2 clocks, then rst=1 for 1 edge, then rst=0 with din still 1.
   - Required: no rise before or during reset; rise occurs 4 edges after reset release; cnt restarts from 1.
5. Back-to-back changes:
   - Stimulus: din=1 for 4 clocks, then immediately 0 for 4 clocks.
   - Required: rise at edge 4, fall at edge 8; rise and fall never overlap.
6. Synchronizer build:
   - Stimulus: DFF_DEBOUNCE_SYNC_EN defined, scenario 3 repeated.
   - Required: rise and fall each appear 2 cycles later than in scenario 3, i.e. at edge k+5 and j+5.
